// File: rtl/user_data_check.sv
// user_data_check: receive-side checker for the user_data_gen frame format.
// Checks the header, payload pattern, length, tkeep and sequence continuity of
// every frame, and keeps per-frame status, sticky flags, counters and a lock.
module user_data_check #(
  parameter logic [15:0] P_MAGIC     = 16'h55D5,
  parameter int unsigned P_MAX_BEATS = 256,
  parameter int unsigned P_LOCK_LOSS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic [63:0] s_axi_rx_tdata,
  input  logic [7:0]  s_axi_rx_tkeep,
  input  logic        s_axi_rx_tlast,
  input  logic        s_axi_rx_tvalid,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic        o_frame_bad,
  output logic [4:0]  o_err_flags,
  output logic [31:0] o_frame_cnt,
  output logic [31:0] o_bad_cnt,
  output logic [15:0] o_last_seq
);

  localparam int unsigned IDX_W = $clog2(P_MAX_BEATS + 1);
  localparam int unsigned RUN_W = $clog2(P_LOCK_LOSS + 1);
  localparam int unsigned ERR_W = 5;
  localparam int unsigned CNT_W = 32;

  // Bit positions inside the {keep, len, seq, data, hdr} error vector.
  localparam int unsigned E_HDR  = 0;
  localparam int unsigned E_DATA = 1;
  localparam int unsigned E_SEQ  = 2;
  localparam int unsigned E_LEN  = 3;
  localparam int unsigned E_KEEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   beat_idx_q;
  logic [15:0]        exp_seq_q;
  logic [15:0]        cur_len_q;
  logic [ERR_W-1:0]   err_q;
  logic [RUN_W-1:0]   bad_run_q;

  logic               magic_ok_c;
  logic [15:0]        hdr_seq_c;
  logic [15:0]        hdr_len_c;
  logic [63:0]        exp_word_c;
  logic               data_mis_c;
  logic               keep_ok_c;
  logic [3:0]         keep_pop_c;
  logic [15:0]        byte_cnt_c;
  logic               at_max_c;
  logic [ERR_W-1:0]   err_new_c;
  logic [ERR_W-1:0]   err_frame_c;
  logic               frame_end_c;
  logic               capture_c;

  // Beat decode: header fields, expected payload word, keep legality, byte count.
  always_comb begin
    magic_ok_c = (s_axi_rx_tdata[63:48] == P_MAGIC);
    hdr_seq_c  = s_axi_rx_tdata[47:32];
    hdr_len_c  = s_axi_rx_tdata[31:16];
    exp_word_c = {16'h0000, o_last_seq, 16'h0000, 16'(beat_idx_q)};
    data_mis_c = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (s_axi_rx_tkeep[b] && (s_axi_rx_tdata[8*b +: 8] != exp_word_c[8*b +: 8])) begin
        data_mis_c = 1'b1;
      end
    end
    if (s_axi_rx_tlast) begin
      case (s_axi_rx_tkeep)
        8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF: keep_ok_c = 1'b1;
        default:                                                keep_ok_c = 1'b0;
      endcase
    end else begin
      keep_ok_c = (s_axi_rx_tkeep == 8'hFF);
    end
    keep_pop_c = 4'($countones(s_axi_rx_tkeep));
    // beat_idx_q counts the full beats before this one (zero for the header).
    byte_cnt_c = 16'({beat_idx_q, 3'b000}) + 16'(keep_pop_c);
    at_max_c   = (beat_idx_q == IDX_W'(P_MAX_BEATS - 1));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; beats only advance the FSM when tvalid is high.
  always_comb begin
    state_d = state_q;
    if (s_axi_rx_tvalid) begin
      case (state_q)
        ST_IDLE: begin
          if (!s_axi_rx_tlast) begin
            state_d = magic_ok_c ? ST_PAYLOAD : ST_DISCARD;
          end
        end
        ST_PAYLOAD: begin
          if (s_axi_rx_tlast) begin
            state_d = ST_IDLE;
          end else if (at_max_c) begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (s_axi_rx_tlast) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Per-beat actions: new errors, header capture and frame end.
  always_comb begin
    err_new_c   = '0;
    frame_end_c = 1'b0;
    capture_c   = 1'b0;
    if (s_axi_rx_tvalid) begin
      case (state_q)
        ST_IDLE: begin
          err_new_c[E_KEEP] = (s_axi_rx_tkeep != 8'hFF);
          if (!magic_ok_c) begin
            err_new_c[E_HDR] = 1'b1;
          end else begin
            capture_c = 1'b1;
            err_new_c[E_SEQ] = o_locked && (hdr_seq_c != exp_seq_q);
            err_new_c[E_LEN] = s_axi_rx_tlast && (byte_cnt_c != hdr_len_c);
          end
          frame_end_c = s_axi_rx_tlast;
        end
        ST_PAYLOAD: begin
          err_new_c[E_DATA] = data_mis_c;
          err_new_c[E_KEEP] = !keep_ok_c;
          if (s_axi_rx_tlast) begin
            err_new_c[E_LEN] = (byte_cnt_c != cur_len_q);
            frame_end_c      = 1'b1;
          end else begin
            err_new_c[E_LEN] = at_max_c;
          end
        end
        ST_DISCARD: begin
          frame_end_c = s_axi_rx_tlast;
        end
        default: begin
          frame_end_c = 1'b0;
        end
      endcase
    end
    err_frame_c = err_q | err_new_c;
  end

  // Frame context, per-frame errors, status outputs, counters and lock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_idx_q   <= '0;
      exp_seq_q    <= '0;
      cur_len_q    <= '0;
      err_q        <= '0;
      bad_run_q    <= '0;
      o_locked     <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_bad  <= 1'b0;
      o_err_flags  <= '0;
      o_frame_cnt  <= '0;
      o_bad_cnt    <= '0;
      o_last_seq   <= '0;
    end else begin
      o_frame_done <= frame_end_c;
      o_frame_bad  <= frame_end_c && (err_frame_c != '0);

      if (capture_c) begin
        o_last_seq <= hdr_seq_c;
        cur_len_q  <= hdr_len_c;
        exp_seq_q  <= hdr_seq_c + 16'd1;
        beat_idx_q <= IDX_W'(1);
      end else if (s_axi_rx_tvalid && (state_q == ST_PAYLOAD)) begin
        beat_idx_q <= beat_idx_q + IDX_W'(1);
      end

      if (frame_end_c) begin
        err_q      <= '0;
        beat_idx_q <= '0;
        if (err_frame_c == '0) begin
          o_locked  <= 1'b1;
          bad_run_q <= '0;
        end else begin
          if (bad_run_q != RUN_W'(P_LOCK_LOSS)) begin
            bad_run_q <= bad_run_q + RUN_W'(1);
          end
          if (bad_run_q >= RUN_W'(P_LOCK_LOSS - 1)) begin
            o_locked <= 1'b0;
          end
        end
      end else begin
        err_q <= err_frame_c;
      end

      // Clear takes priority over a frame ending in the same cycle.
      if (i_clr) begin
        o_frame_cnt <= '0;
        o_bad_cnt   <= '0;
        o_err_flags <= '0;
      end else if (frame_end_c) begin
        o_err_flags <= o_err_flags | err_frame_c;
        if (o_frame_cnt != '1) begin
          o_frame_cnt <= o_frame_cnt + CNT_W'(1);
        end
        if ((err_frame_c != '0) && (o_bad_cnt != '1)) begin
          o_bad_cnt <= o_bad_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_user_data_check.sv
// Bench for user_data_check: directed frames, a frame-level reference model
// compared against the DUT every cycle, and literal spot checks.
module tb_user_data_check;

  localparam logic [15:0] MAGIC = 16'h55D5;
  localparam int          MAXB  = 256;
  localparam int          LL    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;

  logic        locked, frame_done, frame_bad;
  logic [4:0]  err_flags;
  logic [31:0] frame_cnt, bad_cnt;
  logic [15:0] last_seq;

  int errors = 0;
  int checks = 0;
  int printed = 0;
  bit chk_en = 1'b0;

  user_data_check #(.P_MAGIC(MAGIC), .P_MAX_BEATS(MAXB), .P_LOCK_LOSS(LL)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .s_axi_rx_tdata(tdata), .s_axi_rx_tkeep(tkeep),
    .s_axi_rx_tlast(tlast), .s_axi_rx_tvalid(tvalid),
    .o_locked(locked), .o_frame_done(frame_done), .o_frame_bad(frame_bad),
    .o_err_flags(err_flags), .o_frame_cnt(frame_cnt), .o_bad_cnt(bad_cnt),
    .o_last_seq(last_seq)
  );

  always #5 clk = ~clk;

  // Reference model state: what the outputs must be after each clock edge.
  logic        m_done, m_bad, m_locked;
  logic [4:0]  m_flags;
  logic [31:0] m_fc, m_bc;
  logic [15:0] m_last_seq, m_exp_seq;
  int          m_run;
  logic [63:0] q_d[$];
  logic [7:0]  q_k[$];

  task automatic model_reset();
    m_done = 0; m_bad = 0; m_locked = 0; m_flags = 0; m_fc = 0; m_bc = 0;
    m_last_seq = 0; m_exp_seq = 0; m_run = 0;
    q_d.delete(); q_k.delete();
  endtask

  // Judge a whole collected frame from the frame-format rules.
  task automatic eval_frame();
    logic [4:0]  e;
    logic [15:0] seq, len;
    logic [63:0] exp_w;
    int          n;
    bit          is_last;
    e = '0;
    n = q_d.size();
    if (q_k[0] != 8'hFF) e[4] = 1'b1;
    if (q_d[0][63:48] != MAGIC) begin
      e[0] = 1'b1;
    end else begin
      seq = q_d[0][47:32];
      len = q_d[0][31:16];
      if (m_locked && seq != m_exp_seq) e[2] = 1'b1;
      m_exp_seq = seq + 16'd1;
      if (n > MAXB) e[3] = 1'b1;
      else if (len != 16'(8 * (n - 1) + $countones(q_k[n-1]))) e[3] = 1'b1;
      for (int k = 1; k < n && k < MAXB; k++) begin
        is_last = (k == n - 1);
        exp_w = {16'h0000, seq, 16'h0000, 16'(k)};
        if (is_last) begin
          if (!(q_k[k] inside {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF})) e[4] = 1'b1;
        end else if (q_k[k] != 8'hFF) begin
          e[4] = 1'b1;
        end
        for (int b = 0; b < 8; b++)
          if (q_k[k][b] && q_d[k][8*b +: 8] != exp_w[8*b +: 8]) e[1] = 1'b1;
      end
    end
    m_done = 1'b1;
    m_bad  = (e != 0);
    m_flags = m_flags | e;
    if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    if (e != 0 && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    if (e == 0) begin
      m_locked = 1'b1; m_run = 0;
    end else begin
      if (m_run < LL) m_run = m_run + 1;
      if (m_run == LL) m_locked = 1'b0;
    end
  endtask

  // Model step at every active edge, from the same inputs the DUT samples.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        logic [31:0] fc_keep, bc_keep;
        m_done = 0; m_bad = 0;
        if (tvalid) begin
          if (q_d.size() == 0 && tdata[63:48] == MAGIC) m_last_seq = tdata[47:32];
          q_d.push_back(tdata);
          q_k.push_back(tkeep);
          if (tlast) begin
            eval_frame();
            q_d.delete(); q_k.delete();
          end
        end
        fc_keep = m_fc; bc_keep = m_bc;
        if (clr) begin
          m_fc = 0; m_bc = 0; m_flags = 0;
        end
      end
    end
  end

  // Cycle compare of every output against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (frame_done !== m_done || frame_bad !== m_bad || err_flags !== m_flags ||
            frame_cnt !== m_fc || bad_cnt !== m_bc || locked !== m_locked ||
            last_seq !== m_last_seq) begin
          errors++;
          if (printed < 40) begin
            printed++;
            $display("FAIL cycle_cmp t=%0t got done=%b bad=%b flags=%b fc=%0d bc=%0d lk=%b seq=%h want done=%b bad=%b flags=%b fc=%0d bc=%0d lk=%b seq=%h",
                     $time, frame_done, frame_bad, err_flags, frame_cnt, bad_cnt, locked, last_seq,
                     m_done, m_bad, m_flags, m_fc, m_bc, m_locked, m_last_seq);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic c);
    @(negedge clk);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1; clr = c;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] magic, input logic [15:0] seq,
                            input logic [15:0] len, input int npay,
                            input logic [7:0] lkeep, input int cbeat,
                            input logic [63:0] cmask, input bit gap, input bit clr_last);
    logic [63:0] d;
    beat({magic, seq, len, 16'h0000}, 8'hFF, npay == 0, clr_last && npay == 0);
    if (gap) idle(1);
    for (int k = 1; k <= npay; k++) begin
      d = {16'h0000, seq, 16'h0000, 16'(k)};
      if (k == cbeat) d = d ^ cmask;
      beat(d, (k == npay) ? lkeep : 8'hFF, k == npay, clr_last && k == npay);
      if (gap) idle(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_locked", 32'(locked), 0);

    // Clean stream.
    for (int s = 0; s < 3; s++) send_frame(MAGIC, 16'(s), 16'd40, 4, 8'hFF, 0, 0, s == 1, 0);
    idle(2);
    chk("clean_frame_cnt", frame_cnt, 3);
    chk("clean_bad_cnt", bad_cnt, 0);
    chk("clean_locked", 32'(locked), 1);
    chk("clean_last_seq", 32'(last_seq), 2);

    // Partial last beat: 35 bytes is correct, 36 is a length error.
    send_frame(MAGIC, 16'd3, 16'd35, 4, 8'hE0, 0, 0, 0, 0);
    send_frame(MAGIC, 16'd4, 16'd36, 4, 8'hE0, 0, 0, 0, 0);
    idle(2);
    chk("partial_flags", 32'(err_flags), 32'h08);
    chk("partial_bad_cnt", bad_cnt, 1);

    // Sequence gap and 16-bit wrap.
    do_reset();
    send_frame(MAGIC, 16'd5, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    send_frame(MAGIC, 16'd6, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    send_frame(MAGIC, 16'd8, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    send_frame(MAGIC, 16'd9, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    idle(2);
    chk("gap_flags", 32'(err_flags), 32'h04);
    chk("gap_bad_cnt", bad_cnt, 1);
    do_reset();
    send_frame(MAGIC, 16'hFFFE, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    send_frame(MAGIC, 16'hFFFF, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    send_frame(MAGIC, 16'h0000, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    idle(2);
    chk("wrap_bad_cnt", bad_cnt, 0);
    chk("wrap_last_seq", 32'(last_seq), 0);

    // Payload corruption, visible and masked by keep.
    send_frame(MAGIC, 16'd1, 16'd40, 4, 8'hFF, 2, 64'h0000_0000_FF00_0000, 0, 0);
    idle(2);
    chk("corrupt_flags", 32'(err_flags), 32'h02);
    do_clr();
    idle(1);
    chk("clr_frame_cnt", frame_cnt, 0);
    send_frame(MAGIC, 16'd2, 16'd36, 4, 8'hF0, 4, 64'h0000_0000_0000_00FF, 1, 0);
    idle(2);
    chk("masked_bad_cnt", bad_cnt, 0);
    chk("masked_frame_cnt", frame_cnt, 1);

    // Bad magic, lock loss, relock with an arbitrary sequence number.
    for (int i = 0; i < 5; i++) send_frame(16'h1234, 16'd3, 16'd24, 2, 8'hFF, 0, 0, i == 2, 0);
    idle(2);
    chk("magic_flags", 32'(err_flags), 32'h01);
    chk("magic_bad_cnt", bad_cnt, 5);
    chk("lock_lost", 32'(locked), 0);
    do_clr();
    send_frame(MAGIC, 16'h0777, 16'd40, 4, 8'hFF, 0, 0, 0, 0);
    idle(2);
    chk("relock", 32'(locked), 1);
    chk("relock_flags", 32'(err_flags), 0);
    chk("relock_last_seq", 32'(last_seq), 32'h0777);

    // Overlength frames, the second completing under clr.
    send_frame(MAGIC, 16'h0778, 16'd40, MAXB + 1, 8'hFF, 0, 0, 0, 0);
    idle(2);
    chk("over_flags", 32'(err_flags), 32'h08);
    chk("over_frame_cnt", frame_cnt, 2);
    send_frame(MAGIC, 16'h0779, 16'd40, MAXB + 1, 8'hFF, 0, 0, 0, 1);
    idle(2);
    chk("over_clr_frame_cnt", frame_cnt, 0);
    chk("over_clr_bad_cnt", bad_cnt, 0);

    // Reset in the middle of a frame, then a header-only frame.
    beat({MAGIC, 16'd5, 16'd40, 16'h0000}, 8'hFF, 0, 0);
    beat({16'h0000, 16'd5, 16'h0000, 16'd1}, 8'hFF, 0, 0);
    do_reset();
    beat({16'h0000, 16'd5, 16'h0000, 16'd2}, 8'hFF, 1, 0);
    idle(2);
    chk("midrst_flags", 32'(err_flags), 32'h01);
    chk("midrst_frame_cnt", frame_cnt, 1);
    send_frame(MAGIC, 16'd9, 16'd8, 0, 8'hFF, 0, 0, 0, 0);
    idle(2);
    chk("hdr_only_bad_cnt", bad_cnt, 1);
    chk("hdr_only_frame_cnt", frame_cnt, 2);
    chk("hdr_only_locked", 32'(locked), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_data_check.md
Name: user_data_check

Overview:
- Receive-side counterpart of user_data_gen. It consumes the AXI-Stream RX output of PHY_Module (m_axis_*) in the PHY RX user clock domain.
- It checks each frame against the team's generator frame format: header, payload pattern, length, tkeep and sequence continuity.
- It reports per-frame status and counters for ILA/ChipScope link bring-up on both GT channels, one instance per channel.

Parameters:
- P_MAGIC, 16'h55D5, header magic expected in word[63:48] of beat 0.
- P_MAX_BEATS, 256, maximum beats per frame including the header beat.
- P_LOCK_LOSS, 4, consecutive bad frames that drop o_locked.

Ports:
- i_clk  in  1  RX user clock (PHY RX clock).
- i_rst  in  1  synchronous active-high reset.
- i_clr  in  1  synchronous clear of counters and sticky flags.
- s_axi_rx_tdata  in  64  stream data.
- s_axi_rx_tkeep  in  8  byte enables; bit7 is the first byte.
- s_axi_rx_tlast  in  1  last beat of frame.
- s_axi_rx_tvalid  in  1  beat valid; there is no tready, so every valid beat is consumed.
- o_locked  out  1  sequence lock established.
- o_frame_done  out  1  one-cycle pulse, frame finished.
- o_frame_bad  out  1  qualifies o_frame_done: frame had at least one error.
- o_err_flags  out  5  sticky flags {keep, len, seq, data, hdr}.
- o_frame_cnt  out  32  total frames ended.
- o_bad_cnt  out  32  frames with any error.
- o_last_seq  out  16  sequence number of the last accepted header.

Behaviour:
- Frame format:
  - Beat 0 (header) = {P_MAGIC, seq[15:0], len[15:0], 16'h0000}. len is the total byte count including the header.
  - Payload beat k (k = 1..n) = {16'h0, seq, 16'h0, k[15:0]}.
  - Non-last beats require tkeep = 8'hFF.
  - The last beat requires an MSB-first contiguous tkeep: 8'h80, C0, E0, F0, F8, FC, FE or FF.
  - A header-only frame (tlast on beat 0, len = 8) is legal.
- Reset: all outputs 0, FSM in IDLE, beat index 0, expected seq 0, bad-run counter 0.
- FSM states: IDLE, PAYLOAD, DISCARD.
- IDLE, on a valid beat:
  - If word[63:48] != P_MAGIC: set the hdr error. Go to DISCARD unless tlast is set; if tlast, end the frame as bad.
  - Otherwise capture seq and len, set o_last_seq, and set beat index to 1.
  - If o_locked and seq != expected: set the seq error.
  - Always set expected = seq+1 (16-bit wrap, FFFF -> 0000).
  - If tlast: end the frame. Otherwise go to PAYLOAD.
- Header keep: beat 0 keep != FF sets the keep error.
- PAYLOAD, on a valid beat:
  - Compare only the bytes whose keep bit is set against the expected pattern; any mismatch sets the data error.
  - An illegal keep sets the keep error.
  - Beat index increments.
  - If the index reaches P_MAX_BEATS without tlast: set the len error and go to DISCARD.
  - On tlast: compare the received byte count, 8*(beats-1) + popcount(last keep), against len. A mismatch sets the len error. Then end the frame.
- DISCARD: ignore beats until a valid tlast, then end the frame as bad.
- Frame end (registered, one cycle after the tlast beat):
  - o_frame_done = 1, and o_frame_bad = OR of all errors in this frame.
  - o_frame_cnt += 1. o_bad_cnt += 1 if the frame was bad.
  - o_err_flags |= per-frame errors.
  - Per-frame errors clear; FSM returns to IDLE.
- Counters saturate at 32'hFFFFFFFF.
- Lock:
  - A good frame sets o_locked = 1 and clears the bad-run counter.
  - A bad frame increments the bad-run counter, saturating at P_LOCK_LOSS.
  - Reaching P_LOCK_LOSS clears o_locked.
  - While unlocked, no seq error is raised; the first good header relocks.
- tvalid low: no state change; frames may have gaps between beats.
- i_clr: zeroes o_frame_cnt, o_bad_cnt and o_err_flags the next cycle. If a frame ends in the same cycle, clr wins and that frame is not counted. FSM, lock and o_last_seq are unaffected.
- i_rst mid-frame: aborts the frame and returns all state to reset values. The following beats are treated as IDLE input, so a mid-frame payload beat raises a hdr error.

Test Plan:
- Clean stream: 3 frames, seq 0,1,2, len 40 (header + 4 full beats) -> 3 done pulses, o_frame_bad=0, o_frame_cnt=3, o_bad_cnt=0, o_locked=1, o_last_seq=2.
- Partial last beat: len 35, last keep 8'hE0 -> good. Same frame with last keep 8'hE0 and len 36 -> len error, o_err_flags=5'b01000.
- Sequence gap: seq 5,6,8 -> third frame bad, seq flag set, expected becomes 9; next seq 9 is good. Also seq FFFF then 0000 -> no error.
- Corrupt payload byte 3 of beat 2 -> data error. A byte corrupted under keep=0 on the last beat -> no error.
- Bad magic 16'h1234 with 3 beats ending in tlast -> DISCARD, one bad frame. Then 4 consecutive bad frames -> o_locked=0. A following good frame with any seq -> o_locked=1, no seq error.
- Overlength frame of P_MAX_BEATS+2 beats -> len error, a single frame end at tlast. Asserting i_clr in the cycle of that frame's completion leaves counters at 0.
